// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : IF->ID skid queue, circular buffer of fetched entries.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if_id_queue #(
  parameter int          DEPTH      = 4,
  parameter int          TARGET     = 0,
  parameter int          GEN_TARGET = TARGET,
  parameter int          XLEN       = 32,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            pc_p4_in,
  input  logic [31:0]                instr_in,
  input  logic                       branch_take_in,
  input  logic                       out_ready,
  output logic                       instr_valid_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            pc_p4_out,
  output logic [31:0]                instr_out,
  output logic                       branch_take_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int   PW      = $clog2(DEPTH);
  localparam int   CW      = $clog2(DEPTH+1);
  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_p4;
    logic [31:0]     instr;
    logic            branch_take;
  } entry_t;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  entry_t        w_wr_entry;
  entry_t        w_head;
  logic          w_not_empty;
  logic          w_push;
  logic          w_pop;

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count != CW'(DEPTH));
  assign w_push      = in_valid && in_ready && !flush;
  assign w_pop       = w_not_empty && out_ready && !flush;
  assign w_wr_entry  = '{pc: pc_in, pc_p4: pc_p4_in, instr: instr_in,
                         branch_take: branch_take_in};

  // Payload storage carries no reset; only pointers/count decide visibility.
  generate
    if (GEN_TARGET == 1) begin : g_storage_fpga
      (* ram_style = "distributed" *) entry_t r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
      end
      assign w_head = r_mem[r_rd_ptr];
    end else begin : g_storage_generic
      entry_t r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
      end
      assign w_head = r_mem[r_rd_ptr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count           = r_count;
  assign instr_valid_out = w_not_empty ? VALID : INVALID;
  assign pc_out          = w_not_empty ? w_head.pc          : '0;
  assign pc_p4_out       = w_not_empty ? w_head.pc_p4       : '0;
  assign instr_out       = w_not_empty ? w_head.instr       : NOP;
  assign branch_take_out = w_not_empty ? w_head.branch_take : 1'b0;

endmodule

`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered fetch entries (power of two, 2..16).
REQ-002 SHALL have parameter GEN_TARGET, default TARGET, passed to storage-primitive selection.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-006 SHALL have port in_valid  input  1  IF presents an entry this cycle.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have ports pc_in, pc_p4_in  input  XLEN each  fetch PC and PC+4.
REQ-009 SHALL have port instr_in  input  instr_t  fetched instruction.
REQ-010 SHALL have port branch_take_in  input  1  predictor taken flag.
REQ-011 SHALL have port out_ready  input  1  ID consumes the head entry this cycle.
REQ-012 SHALL have port instr_valid_out  output  1  head entry valid (VALID/INVALID encoding).
REQ-013 SHALL have ports pc_out, pc_p4_out  output  XLEN each; instr_out  output  instr_t; branch_take_out  output  1  head entry fields.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries {pc, pc_p4, instr, branch_take} with wr_ptr, rd_ptr of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when instr_valid_out && out_ready && !flush.
REQ-017 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-018 Latency SHALL be 1 cycle: an entry pushed at edge N is visible at the outputs after edge N when the queue was empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including at count==1.
REQ-020 Outputs SHALL present the entry at rd_ptr when count>0 with instr_valid_out=VALID.
REQ-021 When count==0, outputs SHALL be forced: instr_out=NOP, pc_out=0, pc_p4_out=0, branch_take_out=0, instr_valid_out=INVALID.
REQ-022 Flush SHALL, at the next edge, set count=0, wr_ptr=rd_ptr=0; flush SHALL take priority over push and pop in the same cycle (both discarded).
REQ-023 Push when full SHALL be impossible (in_ready=0); in_valid while full SHALL hold no state change.
REQ-024 Pop when empty SHALL be impossible (instr_valid_out=0); out_ready while empty SHALL be ignored.
REQ-025 Entry contents SHALL not be cleared on pop or flush; only count/pointers govern visibility.
REQ-026 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-027 On rst_n low, asynchronously: count=0, wr_ptr=0, rd_ptr=0, so outputs immediately show NOP/0/INVALID and in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first valid output after release requires a new push.
REQ-029 Storage array SHALL not require reset.

Verification
REQ-030 DEPTH=4, push pc 0x100,0x104,0x108,0x10C with out_ready=0 -> count=4, in_ready=0, head pc_out=0x100, fifth in_valid ignored.
REQ-031 From full, out_ready=1 four cycles, in_valid=0 -> pc_out sequence 0x100,0x104,0x108,0x10C then instr_out=NOP, instr_valid_out=INVALID, count=0.
REQ-032 Continuous in_valid and out_ready=1 for 10 cycles (pc 0x0..0x24) -> count stays 1, outputs lag input by 1 cycle, pointers wrap twice with no loss.
REQ-033 count=3 with flush=1 and in_valid=1, out_ready=1 same cycle -> next cycle count=0, INVALID, NOP, pushed entry not visible.
REQ-034 rst_n low mid-stream with count=2 -> outputs NOP/INVALID immediately, in_ready=1; after release first push appears 1 cycle later.
REQ-035 branch_take_in=1 on entry 2 of 3 -> branch_take_out=1 only while entry 2 is head.
